// File: rtl/packet_framer.sv
// Packet framer: payload + stream ID -> header, sequence and payload words. Optional FRAMER_SEQ_SKIP_EN adds injectSkip.
// Latency: header valid one cycle after input accept; one idle cycle after the last word.
// Backpressure: words hold while dataOut_ready=0; payloadIn_ready only in IDLE.
module packet_framer #(
    parameter int NUM_STREAMS       = 32,
    parameter int MAX_PAYLOAD_BYTES = 37
) (
    input  logic                           clk,
    input  logic                           reset_b,
    input  logic [0:MAX_PAYLOAD_BYTES*8-1] payloadIn,
    input  logic [5:0]                     payloadLen,
    input  logic [15:0]                    streamId,
    input  logic                           payloadIn_val,
    output logic                           payloadIn_ready,
    output logic                           lenError,
`ifdef FRAMER_SEQ_SKIP_EN
    input  logic                           injectSkip,
`endif
    output logic [31:0]                    dataOut,
    output logic                           dataOut_val,
    output logic                           dataOut_last,
    input  logic                           dataOut_ready
);

    localparam int WORDS_MAX = (MAX_PAYLOAD_BYTES + 3) / 4;
    localparam int PAD_W     = WORDS_MAX * 32;
    localparam int SID_W     = $clog2(NUM_STREAMS);

    typedef enum logic [1:0] {IDLE, HDR, SEQ, DATA} state_t;

    state_t                              state, state_nxt;
    logic [0:PAD_W-1]                    pay_q, pay_masked;
    logic [5:0]                          len_q, len_m1;
    logic [15:0]                         sid_q;
    logic [31:0]                         seq_q, cur_seq;
    logic [3:0]                          idx_q;
    logic                                len_err_q;
    logic [NUM_STREAMS-1:0][31:0]        next_seq;
    logic                                accept, len_ok, is_last, skip, out_xfer;

`ifdef FRAMER_SEQ_SKIP_EN
    assign skip = injectSkip;
`else
    assign skip = 1'b0;
`endif

    assign accept   = payloadIn_val & payloadIn_ready;
    assign out_xfer = dataOut_val & dataOut_ready;
    assign len_ok   = (payloadLen != 6'd0) && (payloadLen <= 6'(MAX_PAYLOAD_BYTES));
    assign cur_seq  = next_seq[streamId[SID_W-1:0]];
    assign len_m1   = len_q - 6'd1;
    assign is_last  = (idx_q == len_m1[5:2]);
    assign lenError = len_err_q;

    // Bytes beyond len are zeroed at capture so DATA words are a plain slice.
    always_comb begin
        pay_masked = '0;
        for (int k = 0; k < MAX_PAYLOAD_BYTES; k++) begin
            if (6'(k) < payloadLen)
                pay_masked[8*k +: 8] = payloadIn[8*k +: 8];
        end
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt       = state;
        payloadIn_ready = 1'b0;
        dataOut         = '0;
        dataOut_val     = 1'b0;
        dataOut_last    = 1'b0;
        case (state)
            IDLE: begin
                payloadIn_ready = reset_b;
                if (accept && len_ok)
                    state_nxt = HDR;
            end
            HDR: begin
                dataOut     = {16'(len_q) + 16'd8, sid_q};
                dataOut_val = 1'b1;
                if (out_xfer)
                    state_nxt = SEQ;
            end
            SEQ: begin
                dataOut     = seq_q;
                dataOut_val = 1'b1;
                if (out_xfer)
                    state_nxt = DATA;
            end
            DATA: begin
                dataOut      = pay_q[{idx_q, 5'b0} +: 32];
                dataOut_val  = 1'b1;
                dataOut_last = is_last;
                if (out_xfer && is_last)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            pay_q     <= '0;
            len_q     <= '0;
            sid_q     <= '0;
            seq_q     <= '0;
            idx_q     <= '0;
            len_err_q <= 1'b0;
            next_seq  <= {NUM_STREAMS{32'd1}};
        end else begin
            len_err_q <= accept & ~len_ok;
            if (accept && len_ok) begin
                pay_q    <= pay_masked;
                len_q    <= payloadLen;
                sid_q    <= streamId;
                seq_q    <= cur_seq + 32'(skip);
                next_seq[streamId[SID_W-1:0]] <= cur_seq + 32'd1 + 32'(skip);
            end
            if (state == SEQ && out_xfer)
                idx_q <= '0;
            else if (state == DATA && out_xfer && !is_last)
                idx_q <= idx_q + 4'd1;
        end
    end

endmodule

// File: tb/tb_packet_framer.sv
// Directed self-checking bench for packet_framer.
module tb_packet_framer;

    logic         clk = 1'b0;
    logic         reset_b;
    logic [0:295] payloadIn;
    logic [5:0]   payloadLen;
    logic [15:0]  streamId;
    logic         payloadIn_val;
    logic         payloadIn_ready;
    logic         lenError;
    logic         injectSkip;
    logic [31:0]  dataOut;
    logic         dataOut_val;
    logic         dataOut_last;
    logic         dataOut_ready;

    int           errors = 0;
    int           checks = 0;
    logic [31:0]  cap_w [0:11];
    logic         cap_l [0:11];
    int           cap_n;
    logic [31:0][31:0] fv;
    logic [0:295] pv;

    always #5 clk = ~clk;

    packet_framer dut (
        .clk             (clk),
        .reset_b         (reset_b),
        .payloadIn       (payloadIn),
        .payloadLen      (payloadLen),
        .streamId        (streamId),
        .payloadIn_val   (payloadIn_val),
        .payloadIn_ready (payloadIn_ready),
        .lenError        (lenError),
`ifdef FRAMER_SEQ_SKIP_EN
        .injectSkip      (injectSkip),
`endif
        .dataOut         (dataOut),
        .dataOut_val     (dataOut_val),
        .dataOut_last    (dataOut_last),
        .dataOut_ready   (dataOut_ready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [0:295] seq_bytes(input int n, input int start);
        logic [0:295] v;
        v = '0;
        for (int k = 0; k < n; k++) v[8*k +: 8] = 8'(start + k);
        return v;
    endfunction

    // Called at a negedge; returns at the negedge after the accepting posedge.
    task automatic put(input logic [15:0] sid, input logic [5:0] len, input logic [0:295] pay,
                       input logic skip);
        payloadIn     = pay;
        payloadLen    = len;
        streamId      = sid;
        injectSkip    = skip;
        payloadIn_val = 1'b1;
        for (int i = 0; i < 50 && !payloadIn_ready; i++) @(negedge clk);
        chk("put_ready", payloadIn_ready, 1'b1);
        @(negedge clk);
        payloadIn_val = 1'b0;
        injectSkip    = 1'b0;
    endtask

    task automatic collect(input bit toggle);
        logic [31:0] held_w;
        logic        held_l;
        bit          stalled;
        bit          done;
        cap_n = 0;
        done  = 1'b0;
        dataOut_ready = 1'b1;
        for (int cyc = 0; cyc < 100 && !done; cyc++) begin
            stalled = dataOut_val && !dataOut_ready;
            held_w  = dataOut;
            held_l  = dataOut_last;
            if (dataOut_val && dataOut_ready && cap_n < 12) begin
                cap_w[cap_n] = dataOut;
                cap_l[cap_n] = dataOut_last;
                cap_n++;
                done = dataOut_last;
            end
            @(negedge clk);
            if (stalled) begin
                chk("stall_hold_w", dataOut, held_w);
                chk("stall_hold_last", 32'(dataOut_last), 32'(held_l));
            end
            if (toggle) dataOut_ready = ~dataOut_ready;
        end
        chk("collect_done", 32'(done), 1);
        dataOut_ready = 1'b1;
    endtask

    initial begin
        reset_b = 1'b0; payloadIn = '0; payloadLen = '0; streamId = '0;
        payloadIn_val = 1'b0; injectSkip = 1'b0; dataOut_ready = 1'b1;
        #3;
        chk("rst_ready", payloadIn_ready, 0);
        chk("rst_val", dataOut_val, 0);
        chk("rst_last", dataOut_last, 0);
        chk("rst_data", dataOut, 0);
        chk("rst_lenerr", lenError, 0);
        @(negedge clk);
        reset_b = 1'b1;
        #1 chk("post_rst_ready", payloadIn_ready, 1);
        @(negedge clk);

        // Stream 3, five bytes
        pv = '0; pv[0:39] = 40'h1122334455;
        put(16'd3, 6'd5, pv, 1'b0);
        chk("hdr_latency_val", dataOut_val, 1);
        collect(1'b0);
        chk("t1_nwords", cap_n, 4);
        chk("t1_hdr", cap_w[0], 32'h000D0003);
        chk("t1_seq", cap_w[1], 32'h00000001);
        chk("t1_d0", cap_w[2], 32'h11223344);
        chk("t1_d1", cap_w[3], 32'h55000000);
        chk("t1_last0", cap_l[0], 0);
        chk("t1_last2", cap_l[2], 0);
        chk("t1_last3", cap_l[3], 1);

        // Same stream again, then a fresh stream
        pv = '0; pv[0:7] = 8'hAA;
        put(16'd3, 6'd1, pv, 1'b0);
        collect(1'b0);
        chk("t2_nwords", cap_n, 3);
        chk("t2_hdr", cap_w[0], 32'h00090003);
        chk("t2_seq", cap_w[1], 32'h00000002);
        chk("t2_d0", cap_w[2], 32'hAA000000);
        put(16'd7, 6'd4, seq_bytes(4, 1), 1'b0);
        collect(1'b0);
        chk("t3_hdr", cap_w[0], 32'h000C0007);
        chk("t3_seq", cap_w[1], 32'h00000001);
        chk("t3_d0", cap_w[2], 32'h01020304);
        chk("t3_last", cap_l[2], 1);

        // Maximum length with toggling backpressure
        put(16'd5, 6'd37, seq_bytes(37, 1), 1'b0);
        collect(1'b1);
        chk("t4_nwords", cap_n, 12);
        chk("t4_hdr", cap_w[0], 32'h002D0005);
        chk("t4_seq", cap_w[1], 32'h00000001);
        for (int i = 0; i < 9; i++)
            chk("t4_data", cap_w[2+i], {8'(4*i+1), 8'(4*i+2), 8'(4*i+3), 8'(4*i+4)});
        chk("t4_d9", cap_w[11], 32'h25000000);
        chk("t4_last_mid", cap_l[10], 0);
        chk("t4_last_end", cap_l[11], 1);

        // Illegal lengths
        put(16'd9, 6'd0, seq_bytes(4, 1), 1'b0);
        chk("len0_err", lenError, 1);
        chk("len0_noval", dataOut_val, 0);
        @(negedge clk);
        chk("len0_err_pulse", lenError, 0);
        put(16'd9, 6'd38, seq_bytes(37, 1), 1'b0);
        chk("len38_err", lenError, 1);
        chk("len38_noval", dataOut_val, 0);
        @(negedge clk);
        chk("len38_err_pulse", lenError, 0);
        put(16'd9, 6'd2, seq_bytes(2, 8'h40), 1'b0);
        collect(1'b0);
        chk("len_after_seq", cap_w[1], 32'h00000001);
        chk("len_after_d0", cap_w[2], 32'h40410000);

        // Counter wrap on stream 0, aliasing via upper streamId bits
        reset_b = 1'b0;
        @(negedge clk);
        reset_b = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 32; i++) fv[i] = 32'd1;
        fv[0] = 32'hFFFFFFFF;
        force dut.next_seq = fv;
        @(negedge clk);
        release dut.next_seq;
        put(16'd0, 6'd1, seq_bytes(1, 1), 1'b0);
        collect(1'b0);
        chk("wrap_seq_max", cap_w[1], 32'hFFFFFFFF);
        put(16'd0, 6'd1, seq_bytes(1, 1), 1'b0);
        collect(1'b0);
        chk("wrap_seq_zero", cap_w[1], 32'h00000000);
        put(16'h0020, 6'd1, seq_bytes(1, 1), 1'b0);
        collect(1'b0);
        chk("alias_hdr", cap_w[0], 32'h00090020);
        chk("alias_seq", cap_w[1], 32'h00000001);

        // Reset while DATA word 2 is on the bus
        put(16'd4, 6'd16, seq_bytes(16, 8'hA0), 1'b0);
        dataOut_ready = 1'b1;
        for (int i = 0; i < 4; i++) @(negedge clk);
        chk("mid_d2_word", dataOut, 32'hA8A9AAAB);
        chk("mid_d2_val", dataOut_val, 1);
        reset_b = 1'b0;
        #1;
        chk("mid_rst_val", dataOut_val, 0);
        chk("mid_rst_data", dataOut, 0);
        chk("mid_rst_ready", payloadIn_ready, 0);
        @(negedge clk);
        reset_b = 1'b1;
        #1 chk("mid_rel_ready", payloadIn_ready, 1);
        @(negedge clk);
        put(16'd4, 6'd1, seq_bytes(1, 1), 1'b0);
        collect(1'b0);
        chk("mid_restart_seq", cap_w[1], 32'h00000001);
        chk("mid_restart_n", cap_n, 3);

`ifdef FRAMER_SEQ_SKIP_EN
        put(16'd6, 6'd1, seq_bytes(1, 1), 1'b0);
        collect(1'b0);
        chk("skip_seq1", cap_w[1], 32'd1);
        put(16'd6, 6'd1, seq_bytes(1, 1), 1'b1);
        collect(1'b0);
        chk("skip_seq3", cap_w[1], 32'd3);
        put(16'd6, 6'd1, seq_bytes(1, 1), 1'b0);
        collect(1'b0);
        chk("skip_seq4", cap_w[1], 32'd4);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
